// File: rtl/ram_wxd.sv
// DEPTH x WIDTH flop RAM: registered read port with valid strobe, range-error flag, fill engine.
// Optional macro RAM_BYPASS_EN: same-edge read/write to one address forwards din (write-first).
module ram_wxd #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 2
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              write,
  input  logic              read,
  input  logic [ADDR_W-1:0] address,
  input  logic [WIDTH-1:0]  din,
  input  logic              fill,
  input  logic [WIDTH-1:0]  fill_value,
  output logic [WIDTH-1:0]  dout,
  output logic              dout_valid,
  output logic              busy,
  output logic              addr_err
);

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  typedef enum logic {IDLE, FILL} state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [WIDTH-1:0]    mem_d [DEPTH];
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [WIDTH-1:0]    fill_val_q, fill_val_d;
  logic [WIDTH-1:0]    dout_q, dout_d;
  logic                dout_valid_q, dout_valid_d;
  logic                busy_q, busy_d;
  logic                addr_err_q, addr_err_d;
  logic                hit_c;
  logic [WIDTH-1:0]    rd_word_c;

  // State and datapath registers; clear wipes everything including storage.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      fill_val_q   <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      addr_err_q   <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      fill_val_q   <= fill_val_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      busy_q       <= busy_d;
      addr_err_q   <= addr_err_d;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  // Next state: fill runs until the last word is written.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fill) state_d = FILL;
      FILL:    if (ptr_q == LAST_PTR) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: host access in IDLE, one fill word per edge in FILL.
  always_comb begin
    mem_d        = mem_q;
    ptr_d        = ptr_q;
    fill_val_d   = fill_val_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    addr_err_d   = 1'b0;
    busy_d       = (state_d == FILL);
    hit_c        = 1'b0;
    rd_word_c    = '0;
    case (state_q)
      IDLE: begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (address == ADDR_W'(i)) begin
            hit_c     = 1'b1;
            rd_word_c = mem_q[i];
            if (write) mem_d[i] = din;
          end
        end
`ifdef RAM_BYPASS_EN
        if (write && hit_c) rd_word_c = din;
`else
`endif
        if (read) begin
          dout_valid_d = 1'b1;
          dout_d       = hit_c ? rd_word_c : '0;
        end
        addr_err_d = (read | write) & ~hit_c;
        if (fill) begin
          fill_val_d = fill_value;
          ptr_d      = '0;
        end
      end
      FILL: begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (ptr_q == ADDR_W'(i)) mem_d[i] = fill_val_q;
        end
        ptr_d = ptr_q + ADDR_W'(1);
      end
      default: ;
    endcase
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign busy       = busy_q;
  assign addr_err   = addr_err_q;

endmodule

// File: tb/tb_ram_wxd.sv
// Scoreboard bench for ram_wxd: default 4x8 instance plus a DEPTH=3 instance for range errors.
module tb_ram_wxd;

  logic       clk = 1'b0;
  logic       clear;
  logic       write, read, fill;
  logic [1:0] address;
  logic [7:0] din, fill_value;
  logic [7:0] dout;
  logic       dout_valid, busy, addr_err;

  logic       write3, read3, fill3;
  logic [1:0] address3;
  logic [7:0] din3, fill_value3;
  logic [7:0] dout3;
  logic       dout_valid3, busy3, addr_err3;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] q4[$];
  logic [7:0] q3[$];
  logic [7:0] e4, e3;

`ifdef RAM_BYPASS_EN
  localparam logic [7:0] SAME_EXP = 8'h22;
`else
  localparam logic [7:0] SAME_EXP = 8'h11;
`endif

  always #5 clk = ~clk;

  ram_wxd u_dut (
    .clk(clk), .clear(clear), .write(write), .read(read), .address(address),
    .din(din), .fill(fill), .fill_value(fill_value), .dout(dout),
    .dout_valid(dout_valid), .busy(busy), .addr_err(addr_err)
  );

  ram_wxd #(.WIDTH(8), .DEPTH(3), .ADDR_W(2)) u_dut3 (
    .clk(clk), .clear(clear), .write(write3), .read(read3), .address(address3),
    .din(din3), .fill(fill3), .fill_value(fill_value3), .dout(dout3),
    .dout_valid(dout_valid3), .busy(busy3), .addr_err(addr_err3)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endfunction

  task automatic drv(input logic w, input logic r, input logic f,
                     input logic [1:0] a, input logic [7:0] d, input logic [7:0] fv);
    @(negedge clk);
    write = w; read = r; fill = f; address = a; din = d; fill_value = fv;
  endtask

  task automatic drv3(input logic w, input logic r, input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    write3 = w; read3 = r; address3 = a; din3 = d;
  endtask

  // Monitors: every valid read must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (dout_valid) begin
      if (q4.size() == 0) begin
        chk("dut4_unexpected_valid", 32'(dout_valid), 32'd0);
      end else begin
        e4 = q4.pop_front();
        chk("dut4_dout", 32'(dout), 32'(e4));
      end
    end
  end

  always @(negedge clk) begin
    if (dout_valid3) begin
      if (q3.size() == 0) begin
        chk("dut3_unexpected_valid", 32'(dout_valid3), 32'd0);
      end else begin
        e3 = q3.pop_front();
        chk("dut3_dout", 32'(dout3), 32'(e3));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] wv [4];
    wv[0] = 8'h03; wv[1] = 8'h0C; wv[2] = 8'h30; wv[3] = 8'hC0;
    clear = 1'b0;
    write = 1'b0; read = 1'b0; fill = 1'b0; address = '0; din = '0; fill_value = '0;
    write3 = 1'b0; read3 = 1'b0; fill3 = 1'b0; address3 = '0; din3 = '0; fill_value3 = '0;

    // Reset
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_valid", 32'(dout_valid), 32'd0);
    chk("rst_addr_err", 32'(addr_err), 32'd0);
    clear = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drv(1'b0, 1'b1, 1'b0, 2'(i), 8'h00, 8'h00);
      q4.push_back(8'h00);
    end

    // Write then read back
    for (int i = 0; i < 4; i++) drv(1'b1, 1'b0, 1'b0, 2'(i), wv[i], 8'h00);
    for (int i = 0; i < 4; i++) begin
      drv(1'b0, 1'b1, 1'b0, 2'(i), 8'h00, 8'h00);
      q4.push_back(wv[i]);
    end
    drv(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 8'h00);
    chk("addr_err_inrange", 32'(addr_err), 32'd0);

    // Fill with 0xA5; accesses during busy are ignored
    drv(1'b0, 1'b0, 1'b1, 2'd0, 8'h00, 8'hA5);
    for (int k = 0; k < 4; k++) begin
      if (k == 1)      drv(1'b0, 1'b1, 1'b0, 2'd2, 8'h00, 8'h00);
      else if (k == 3) drv(1'b1, 1'b0, 1'b0, 2'd1, 8'hFF, 8'h00);
      else             drv(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 8'h00);
      chk("fill_busy_hi", 32'(busy), 32'd1);
    end
    for (int i = 0; i < 4; i++) begin
      drv(1'b0, 1'b1, 1'b0, 2'(i), 8'h00, 8'h00);
      if (i == 0) chk("fill_busy_lo", 32'(busy), 32'd0);
      q4.push_back(8'hA5);
    end
    drv(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 8'h00);

    // Reset during the second fill cycle
    drv(1'b0, 1'b0, 1'b1, 2'd0, 8'h00, 8'h5A);
    drv(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 8'h00);
    chk("mid_busy_hi", 32'(busy), 32'd1);
    @(negedge clk);
    clear = 1'b0;
    #1;
    chk("mid_busy_cleared", 32'(busy), 32'd0);
    chk("mid_dout_cleared", 32'(dout), 32'd0);
    @(negedge clk);
    clear = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drv(1'b0, 1'b1, 1'b0, 2'(i), 8'h00, 8'h00);
      q4.push_back(8'h00);
    end

    // Same-address read and write
    drv(1'b1, 1'b0, 1'b0, 2'd2, 8'h11, 8'h00);
    drv(1'b1, 1'b1, 1'b0, 2'd2, 8'h22, 8'h00);
    q4.push_back(SAME_EXP);
    drv(1'b0, 1'b1, 1'b0, 2'd2, 8'h00, 8'h00);
    q4.push_back(8'h22);
    drv(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 8'h00);

    // Out of range on the DEPTH=3 instance
    drv3(1'b1, 1'b0, 2'd0, 8'h01);
    drv3(1'b1, 1'b0, 2'd1, 8'h02);
    drv3(1'b1, 1'b0, 2'd2, 8'h03);
    chk("oor_err_before", 32'(addr_err3), 32'd0);
    drv3(1'b1, 1'b0, 2'd3, 8'h77);
    drv3(1'b0, 1'b1, 2'd3, 8'h00);
    chk("oor_err_write", 32'(addr_err3), 32'd1);
    q3.push_back(8'h00);
    drv3(1'b0, 1'b0, 2'd0, 8'h00);
    chk("oor_err_read", 32'(addr_err3), 32'd1);
    for (int i = 0; i < 3; i++) begin
      drv3(1'b0, 1'b1, 2'(i), 8'h00);
      if (i == 0) chk("oor_err_cleared", 32'(addr_err3), 32'd0);
      q3.push_back(8'(i + 1));
    end
    drv3(1'b0, 1'b0, 2'd0, 8'h00);
    chk("oor_busy3", 32'(busy3), 32'd0);

    repeat (3) @(negedge clk);
    chk("q4_drained", 32'(q4.size()), 32'd0);
    chk("q3_drained", 32'(q3.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
